// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - core/DMA data memory arbiter with burst limit
// Fixed core priority by default; round-robin when DMEM_ARB_RR_EN is defined.
module data_mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

`ifdef DMEM_ARB_RR_EN
    localparam logic LP_RR_EN = 1'b1;
`else
    localparam logic LP_RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_CORE = 2'd1,
        GNT_DMA  = 2'd2
    } state_t;

    typedef enum logic {
        LAST_CORE = 1'b0,
        LAST_DMA  = 1'b1
    } last_t;

    state_t      r_state;
    state_t      w_state_next;
    last_t       r_last_grant;
    logic [3:0]  r_burst;
    logic [3:0]  w_burst_inc;
    logic        w_burst_last;
    logic        w_pick_dma;
    logic        w_core_xfer;
    logic        w_dma_xfer;
    logic        r_core_rvalid;
    logic        r_dma_rvalid;
    logic [31:0] r_core_rdata;
    logic [31:0] r_dma_rdata;

    assign core_gnt    = (r_state == GNT_CORE);
    assign dma_gnt     = (r_state == GNT_DMA);
    assign w_core_xfer = core_gnt && core_req;
    assign w_dma_xfer  = dma_gnt && dma_req;

    // Saturate so a long uncontested burst cannot wrap back under the limit.
    assign w_burst_inc  = (r_burst == 4'hF) ? r_burst : r_burst + 4'd1;
    assign w_burst_last = ((32'(r_burst) + 32'd1) >= MAX_BURST);
    assign w_pick_dma   = LP_RR_EN && (r_last_grant == LAST_CORE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (core_req && dma_req) begin
                    w_state_next = w_pick_dma ? GNT_DMA : GNT_CORE;
                end else if (core_req) begin
                    w_state_next = GNT_CORE;
                end else if (dma_req) begin
                    w_state_next = GNT_DMA;
                end
            end
            GNT_CORE: begin
                if (!core_req) begin
                    w_state_next = dma_req ? GNT_DMA : IDLE;
                end else if (dma_req && LP_RR_EN && w_burst_last) begin
                    w_state_next = GNT_DMA;
                end
            end
            GNT_DMA: begin
                // Without round-robin the core preempts after the current DMA transfer.
                if (!dma_req) begin
                    w_state_next = core_req ? GNT_CORE : IDLE;
                end else if (core_req && (!LP_RR_EN || w_burst_last)) begin
                    w_state_next = GNT_CORE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= IDLE;
            r_burst      <= 4'd0;
            r_last_grant <= LAST_DMA;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_burst <= 4'd0;
                if (w_state_next == GNT_CORE) begin
                    r_last_grant <= LAST_CORE;
                end else if (w_state_next == GNT_DMA) begin
                    r_last_grant <= LAST_DMA;
                end
            end else if (w_core_xfer || w_dma_xfer) begin
                r_burst <= w_burst_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_core_rvalid <= 1'b0;
            r_dma_rvalid  <= 1'b0;
            r_core_rdata  <= 32'd0;
            r_dma_rdata   <= 32'd0;
        end else begin
            r_core_rvalid <= w_core_xfer && !core_we;
            r_dma_rvalid  <= w_dma_xfer && !dma_we;
            if (w_core_xfer && !core_we) begin
                r_core_rdata <= mem_RD;
            end
            if (w_dma_xfer && !dma_we) begin
                r_dma_rdata <= mem_RD;
            end
        end
    end

    assign core_rvalid = r_core_rvalid;
    assign dma_rvalid  = r_dma_rvalid;
    assign core_rdata  = r_core_rdata;
    assign dma_rdata   = r_dma_rdata;

    always_comb begin
        mem_A  = 32'd0;
        mem_WD = 32'd0;
        mem_WE = 1'b0;
        case (r_state)
            GNT_CORE: begin
                mem_A  = core_addr;
                mem_WD = core_wdata;
                mem_WE = w_core_xfer && core_we;
            end
            GNT_DMA: begin
                mem_A  = dma_addr;
                mem_WD = dma_wdata;
                mem_WE = w_dma_xfer && dma_we;
            end
            default: begin
                mem_A  = 32'd0;
                mem_WD = 32'd0;
                mem_WE = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

    logic        CLK;
    logic        RSTn;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    logic [31:0] tb_mem [64] = '{default: 32'h0};
    logic [31:0] core_expq [$];
    logic [31:0] dma_expq [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    data_mem_arbiter #(.MAX_BURST(4)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_RD = (mem_A == 32'h10) ? 32'hDEAD_BEEF : tb_mem[mem_A[7:2]];

    always @(posedge CLK) begin
        if (mem_WE) tb_mem[mem_A[7:2]] <= mem_WD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (core_rvalid) begin
            if (core_expq.size() == 0) chk1("core_rvalid_unexpected", core_rvalid, 1'b0);
            else chk("core_rdata", core_rdata, core_expq.pop_front());
        end
        if (dma_rvalid) begin
            if (dma_expq.size() == 0) chk1("dma_rvalid_unexpected", dma_rvalid, 1'b0);
            else chk("dma_rdata", dma_rdata, dma_expq.pop_front());
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic dma_read(input logic [31:0] a, input logic [31:0] exp);
        int n;
        dma_expq.push_back(exp);
        tick;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = a;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!dma_gnt && n < 8);
        chk1("dma_read_gnt", dma_gnt, 1'b1);
        tick;
        dma_req = 1'b0;
        repeat (3) tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RSTn = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = 32'h0; dma_wdata  = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk1("rst_core_gnt", core_gnt, 1'b0);
        chk1("rst_dma_gnt", dma_gnt, 1'b0);
        chk1("rst_core_rvalid", core_rvalid, 1'b0);
        chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        chk1("rst_mem_we", mem_WE, 1'b0);
        chk("rst_mem_a", mem_A, 32'h0);
        tick;
        RSTn = 1'b1;

        // core read of 0x10
        core_expq.push_back(32'hDEAD_BEEF);
        tick;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        @(negedge CLK);
        chk1("rd_gnt_c0", core_gnt, 1'b0);
        tick; @(negedge CLK);
        chk1("rd_gnt_c1", core_gnt, 1'b1);
        chk1("rd_dma_gnt_c1", dma_gnt, 1'b0);
        chk("rd_mem_a", mem_A, 32'h10);
        chk1("rd_mem_we", mem_WE, 1'b0);
        tick;
        core_req = 1'b0;
        @(negedge CLK);
        chk1("rd_rvalid_c2", core_rvalid, 1'b1);
        tick; @(negedge CLK);
        chk1("rd_rvalid_c3", core_rvalid, 1'b0);
        chk1("rd_idle_c3", core_gnt, 1'b0);
        chk("rd_rdata_hold", core_rdata, 32'hDEAD_BEEF);

        // DMA write 0x1234 to 0x20
        tick;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h1234;
        @(negedge CLK);
        chk1("wr_we_c0", mem_WE, 1'b0);
        tick; @(negedge CLK);
        chk1("wr_gnt_c1", dma_gnt, 1'b1);
        chk1("wr_we_c1", mem_WE, 1'b1);
        chk("wr_mem_a", mem_A, 32'h20);
        chk("wr_mem_wd", mem_WD, 32'h1234);
        tick;
        dma_req = 1'b0; dma_we = 1'b0;
        @(negedge CLK);
        chk1("wr_bubble_gnt", dma_gnt, 1'b1);
        chk1("wr_we_c2", mem_WE, 1'b0);
        tick; @(negedge CLK);
        chk1("wr_idle", dma_gnt, 1'b0);
        dma_read(32'h20, 32'h1234);

`ifndef DMEM_ARB_RR_EN
        // fixed priority: core preempts a DMA burst after one more transfer
        tick;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h55;
        tick;
        tick; @(negedge CLK);
        chk1("fp_dma_burst", dma_gnt, 1'b1);
        tick;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        @(negedge CLK);
        chk1("fp_last_dma_gnt", dma_gnt, 1'b1);
        chk1("fp_last_dma_we", mem_WE, 1'b1);
        chk1("fp_core_wait", core_gnt, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick; @(negedge CLK);
            chk1("fp_core_gnt", core_gnt, 1'b1);
            chk1("fp_dma_starved", dma_gnt, 1'b0);
            core_expq.push_back(32'hDEAD_BEEF);
        end
        tick;
        core_req = 1'b0;
        @(negedge CLK);
        chk1("fp_core_bubble_gnt", core_gnt, 1'b1);
        chk1("fp_core_bubble_we", mem_WE, 1'b0);
        tick; @(negedge CLK);
        chk1("fp_handover_dma", dma_gnt, 1'b1);
        chk1("fp_handover_core", core_gnt, 1'b0);
        chk1("fp_handover_we", mem_WE, 1'b1);
        tick;
        dma_req = 1'b0; dma_we = 1'b0;
        tick; tick;
        dma_read(32'h30, 32'h55);
`endif

        // grant drops to IDLE on a one-cycle request gap
        tick;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h34; core_wdata = 32'hCAFE;
        tick; @(negedge CLK);
        chk1("gap_gnt", core_gnt, 1'b1);
        chk1("gap_we", mem_WE, 1'b1);
        tick;
        core_req = 1'b0;
        @(negedge CLK);
        chk1("gap_bubble_gnt", core_gnt, 1'b1);
        chk1("gap_bubble_we", mem_WE, 1'b0);
        tick; @(negedge CLK);
        chk1("gap_idle", core_gnt, 1'b0);
        tick;
        core_req = 1'b1;
        @(negedge CLK);
        chk1("gap_regnt_c0", core_gnt, 1'b0);
        tick; @(negedge CLK);
        chk1("gap_regnt_c1", core_gnt, 1'b1);
        chk("gap_mem_wd", mem_WD, 32'hCAFE);
        tick;
        core_req = 1'b0; core_we = 1'b0;
        tick; tick;

        // asynchronous reset during a write
        tick;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h38; core_wdata = 32'hBEEF;
        dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'h3C; dma_wdata  = 32'h77;
        tick;
        chk1("ar_we_before", mem_WE, 1'b1);
        #1;
        RSTn = 1'b0;
        #1;
        chk1("ar_we", mem_WE, 1'b0);
        chk1("ar_core_gnt", core_gnt, 1'b0);
        chk1("ar_dma_gnt", dma_gnt, 1'b0);
        chk1("ar_core_rvalid", core_rvalid, 1'b0);
        chk1("ar_dma_rvalid", dma_rvalid, 1'b0);
        @(negedge CLK);
        tick;
        RSTn = 1'b1;
        @(negedge CLK);
        chk1("ar_idle_core", core_gnt, 1'b0);
        chk1("ar_idle_dma", dma_gnt, 1'b0);
        tick; @(negedge CLK);
        chk1("ar_first_core", core_gnt, 1'b1);
        chk1("ar_first_dma", dma_gnt, 1'b0);
        tick;
        core_req = 1'b0; dma_req = 1'b0;
        tick; tick; tick;

`ifdef DMEM_ARB_RR_EN
        // round-robin: 4 core, 4 DMA, 4 core with no bubbles
        RSTn = 1'b0;
        tick; tick;
        RSTn = 1'b1;
        tick;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h1;
        dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'h44; dma_wdata  = 32'h2;
        for (int i = 0; i < 12; i++) begin
            logic exp_core;
            tick; @(negedge CLK);
            exp_core = (((i / 4) % 2) == 0);
            chk1("rr_core_gnt", core_gnt, exp_core);
            chk1("rr_dma_gnt", dma_gnt, !exp_core);
            chk1("rr_no_bubble", mem_WE, 1'b1);
        end
        tick;
        core_req = 1'b0; dma_req = 1'b0;
        tick; tick; tick;
`endif

        chk("core_q_drained", 32'(core_expq.size()), 32'd0);
        chk("dma_q_drained", 32'(dma_expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
